// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal TX FIFO.
// The host writes words through a valid/ready port. The FSM sends queued frames
// back-to-back, LSB first: a start bit, DATA_BITS data bits, an optional parity
// bit and STOP_BITS stop bits. The bit period is the divisor latched at frame
// start, clamped to at least 2 clock cycles.
// Optional feature macro: UART_TX_PARITY_EN.
//   When defined, the PARITY state is compiled in and parity_en/parity_odd are honoured.
//   When undefined, frames carry no parity bit and the two parity inputs are ignored.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16,
    parameter int FIFO_AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done,
    output logic [FIFO_AW:0]     fifo_count
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
    localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW:0]     wr_ptr;
    logic [FIFO_AW:0]     rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Pointers carry one extra wrap bit, so equal low bits with different wrap bits mean full.
    assign fifo_count = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign data_ready = !full;
    assign push       = data_valid && !full;
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];

    // Storage array: written on accepted pushes; its contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= data_in;
        end
    end

    // Read/write pointers: a reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [DIV_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_l;
    logic [DIV_W-1:0]     div_next;
    logic [3:0]           bit_idx;
    logic [1:0]           stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
    logic                 last_stop;

`ifdef UART_TX_PARITY_EN
    logic                 par_en_l;
    logic                 par_bit;
`else
    logic                 unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    // Divisors 0 and 1 cannot give a usable bit period, so they clamp to 2.
    assign div_next  = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
    assign bit_end   = (bit_cnt == div_l - DIV_ONE);
    assign last_stop = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
    // The next word is taken either from idle or at the end of the last stop
    // bit, so consecutive frames touch with no idle bit between them.
    assign pop       = !empty && ((state == IDLE) || last_stop);
    assign busy      = (state != IDLE);

    // Frame sequencer: owns tx, tx_done, bit timing and the latched frame configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                // Frame start: latch the word and the line configuration, drive the start bit
                state    <= START;
                tx       <= 1'b0;
                tx_done  <= last_stop;
                bit_cnt  <= '0;
                bit_idx  <= '0;
                stop_idx <= '0;
                shreg    <= head;
                div_l    <= div_next;
`ifdef UART_TX_PARITY_EN
                par_en_l <= parity_en;
                par_bit  <= (^head) ^ parity_odd;
`endif
            end else begin
                if (state != IDLE) begin
                    bit_cnt <= bit_end ? '0 : bit_cnt + DIV_ONE;
                end
                case (state)
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                                if (par_en_l) begin
                                    state <= PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state    <= STOP;
                                    tx       <= 1'b1;
                                    stop_idx <= '0;
                                end
`else
                                state    <= STOP;
                                tx       <= 1'b1;
                                stop_idx <= '0;
`endif
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                tx      <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_idx <= '0;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            if (stop_idx == STOP_LAST) begin
                                // Queue empty at the end of the frame: return to idle
                                state   <= IDLE;
                                tx      <= 1'b1;
                                tx_done <= 1'b1;
                            end else begin
                                stop_idx <= stop_idx + 2'd1;
                            end
                        end
                    end
                    default: begin
                        tx <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. It runs two instances side by side on the same
// stimulus: 8 data bits with 1 stop bit, and 7 data bits with 2 stop bits.
// Both frame shapes have the same bit count, so the two FIFOs stay in lockstep.
// Expected line waveforms are built from the queued words and divisors.
module tb_uart_tx_fifo;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] baud_div;
    logic             parity_en;
    logic             parity_odd;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready, tx, busy, tx_done;
    logic [3:0]       fifo_count;
    logic             data_ready7, tx7, busy7, tx_done7;
    logic [3:0]       fifo_count7;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wq[$];
    int         lq[$];
    bit         penq[$];
    bit         poddq[$];
    logic [2:0] rec0[$], rec1[$], exp0[$], exp1[$];
    bit         rec_en = 1'b0;

    always #10 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(DIV_W), .FIFO_AW(3)) u_dut8 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx(tx), .busy(busy), .tx_done(tx_done),
        .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .DIV_W(DIV_W), .FIFO_AW(3)) u_dut7 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .data_in(data_in[6:0]), .data_valid(data_valid),
        .data_ready(data_ready7), .tx(tx7), .busy(busy7), .tx_done(tx_done7),
        .fifo_count(fifo_count7)
    );

    // Line monitor: one {busy, tx_done, tx} sample per cycle, taken on the falling edge
    always @(negedge clk) begin
        if (rec_en) begin
            rec0.push_back({busy, tx_done, tx});
            rec1.push_back({busy7, tx_done7, tx7});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Expected line: two idle samples before the first pop, then contiguous
    // frames, each bit held for L cycles. tx_done is seen in the first sample
    // after each frame's last stop bit.
    task automatic build_model(input int db, input int sb, output logic [2:0] e[$]);
        int bits[$];
        int ones;
        bit par;
        e = {};
        e.push_back(3'b001);
        e.push_back(3'b001);
        for (int f = 0; f < wq.size(); f++) begin
            bits = {};
            ones = 0;
            bits.push_back(0);
            for (int i = 0; i < db; i++) begin
                bits.push_back(int'(wq[f][i]));
                ones += int'(wq[f][i]);
            end
`ifdef UART_TX_PARITY_EN
            par = penq[f];
`else
            par = 1'b0;
`endif
            if (par) bits.push_back((ones % 2) ^ int'(poddq[f]));
            for (int i = 0; i < sb; i++) bits.push_back(1);
            for (int b = 0; b < bits.size(); b++)
                for (int c = 0; c < lq[f]; c++)
                    e.push_back({1'b1, (f > 0 && b == 0 && c == 0), bits[b] != 0});
        end
        e.push_back(3'b011);
        for (int i = 0; i < 3; i++) e.push_back(3'b001);
    endtask

    function automatic int first_diff(input logic [2:0] a[$], input logic [2:0] b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic logic [2:0] at(input logic [2:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 3'bxxx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic queue_frame(input logic [7:0] w, input int b, input bit pen, input bit podd);
        wq.push_back(w);
        lq.push_back((b < 2) ? 2 : b);
        penq.push_back(pen);
        poddq.push_back(podd);
    endtask

    task automatic clear_frames();
        wq = {}; lq = {}; penq = {}; poddq = {};
    endtask

    task automatic start_record();
        build_model(8, 1, exp0);
        build_model(7, 2, exp1);
        rec0 = {};
        rec1 = {};
        rec_en = 1'b1;
    endtask

    task automatic push_words();
        int guard;
        for (int i = 0; i < wq.size(); i++) begin
            data_in    = wq[i];
            data_valid = 1'b1;
            guard = 0;
            while (!(data_ready && data_ready7) && guard < 5000) begin
                step();
                guard++;
            end
            if (guard >= 5000) begin
                n_checks++; n_fail++;
                $display("FAIL push_timeout word %0d: got data_ready=0, expected 1", i);
            end
            step();
        end
        data_valid = 1'b0;
    endtask

    task automatic finish_record();
        int guard;
        guard = 0;
        while (rec0.size() < exp0.size() && guard < 20000) begin
            step();
            guard++;
        end
        rec_en = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy || busy7 || fifo_count != 0 || fifo_count7 != 0) && guard < 20000) begin
            step();
            guard++;
        end
        if (guard >= 20000) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: got busy=%b count=%0d, expected idle and empty", busy, fifo_count);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b0; data_in = '0; baud_div = 16'd4;
        parity_en = 1'b0; parity_odd = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({tx, busy, tx_done, data_ready, fifo_count} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_dut8: got tx,busy,done,ready,count=%b, expected 10010000",
                     {tx, busy, tx_done, data_ready, fifo_count});
        end
        n_checks++;
        if ({tx7, busy7, tx_done7, data_ready7, fifo_count7} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_dut7: got tx,busy,done,ready,count=%b, expected 10010000",
                     {tx7, busy7, tx_done7, data_ready7, fifo_count7});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        int d, fi, di;
        baud_div = 16'd4; parity_en = 1'b0;
        clear_frames();
        queue_frame(8'h55, 4, 1'b0, 1'b0);
        start_record();
        push_words();
        finish_record();
        d = first_diff(rec0, exp0); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL single_wave8 sample %0d: got %b, expected %b", d, at(rec0, d), at(exp0, d));
        end
        d = first_diff(rec1, exp1); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL single_wave7 sample %0d: got %b, expected %b", d, at(rec1, d), at(exp1, d));
        end
        fi = -1; di = -1;
        for (int i = 0; i < rec0.size(); i++) begin
            if (fi < 0 && rec0[i][0] == 1'b0) fi = i;
            if (di < 0 && rec0[i][1] == 1'b1) di = i;
        end
        n_checks++;
        if (fi !== 2) begin
            n_fail++;
            $display("FAIL single_latency: got tx fall at sample %0d, expected 2", fi);
        end
        n_checks++;
        if (di - fi !== 40) begin
            n_fail++;
            $display("FAIL single_done_time: got %0d cycles fall-to-done, expected 40", di - fi);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int d;
        baud_div = 16'd2; parity_en = 1'b0;
        clear_frames();
        for (int i = 0; i < 9; i++) queue_frame(8'($urandom_range(0, 255)), 2, 1'b0, 1'b0);
        start_record();
        push_words();
        n_checks++;
        if ({data_ready, data_ready7} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_ready_after_9: got %b, expected 00", {data_ready, data_ready7});
        end
        n_checks++;
        if ({fifo_count, fifo_count7} !== {4'd8, 4'd8}) begin
            n_fail++;
            $display("FAIL b2b_count_full: got %0d/%0d, expected 8/8", fifo_count, fifo_count7);
        end
        data_in = 8'hA5; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        n_checks++;
        if ({fifo_count, fifo_count7} !== {4'd8, 4'd8}) begin
            n_fail++;
            $display("FAIL b2b_write_when_full: got %0d/%0d, expected 8/8", fifo_count, fifo_count7);
        end
        finish_record();
        d = first_diff(rec0, exp0); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL b2b_wave8 sample %0d: got %b, expected %b", d, at(rec0, d), at(exp0, d));
        end
        d = first_diff(rec1, exp1); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL b2b_wave7 sample %0d: got %b, expected %b", d, at(rec1, d), at(exp1, d));
        end
        wait_idle();
    endtask

    task automatic test_parity();
        int d;
        for (int odd = 0; odd < 2; odd++) begin
            baud_div = 16'd3; parity_en = 1'b1; parity_odd = odd[0];
            clear_frames();
            queue_frame(8'h07, 3, 1'b1, odd[0]);
            start_record();
            push_words();
            finish_record();
            d = first_diff(rec0, exp0); n_checks++;
            if (d != -1) begin
                n_fail++;
                $display("FAIL parity_wave8 odd=%0d sample %0d: got %b, expected %b", odd, d, at(rec0, d), at(exp0, d));
            end
            d = first_diff(rec1, exp1); n_checks++;
            if (d != -1) begin
                n_fail++;
                $display("FAIL parity_wave7 odd=%0d sample %0d: got %b, expected %b", odd, d, at(rec1, d), at(exp1, d));
            end
`ifdef UART_TX_PARITY_EN
            n_checks++;
            if (at(rec0, 30) !== {2'b10, ~odd[0]}) begin
                n_fail++;
                $display("FAIL parity_bit odd=%0d: got %b, expected %b", odd, at(rec0, 30), {2'b10, ~odd[0]});
            end
`endif
            wait_idle();
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_baud_change();
        int d;
        baud_div = 16'd0; parity_en = 1'b0;
        clear_frames();
        queue_frame(8'hC3, 0, 1'b0, 1'b0);
        queue_frame(8'h5A, 8, 1'b0, 1'b0);
        start_record();
        fork
            push_words();
            begin
                repeat (6) step();
                baud_div = 16'd8;
            end
        join
        finish_record();
        d = first_diff(rec0, exp0); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL baud_wave8 sample %0d: got %b, expected %b", d, at(rec0, d), at(exp0, d));
        end
        d = first_diff(rec1, exp1); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL baud_wave7 sample %0d: got %b, expected %b", d, at(rec1, d), at(exp1, d));
        end
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        int guard, bad0, bad1;
        logic [2:0] pre0[$], pre1[$], e0[$], e1[$];
        baud_div = 16'd4; parity_en = 1'b0;
        clear_frames();
        for (int i = 0; i < 3; i++) queue_frame(8'($urandom_range(0, 255)), 4, 1'b0, 1'b0);
        start_record();
        push_words();
        guard = 0;
        while (rec0.size() < 56 && guard < 1000) begin
            step();
            guard++;
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({tx, busy, data_ready, fifo_count, tx7, busy7, data_ready7, fifo_count7} !==
            {3'b101, 4'd0, 3'b101, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_state: got tx,busy,ready,count=%b/%b, expected 1010000/1010000",
                     {tx, busy, data_ready, fifo_count}, {tx7, busy7, data_ready7, fifo_count7});
        end
        pre0 = rec0[0:55]; pre1 = rec1[0:55];
        e0 = exp0[0:55];   e1 = exp1[0:55];
        n_checks++;
        if (first_diff(pre0, e0) != -1 || first_diff(pre1, e1) != -1) begin
            n_fail++;
            $display("FAIL rst_mid_prefix: got first differing samples %0d/%0d, expected -1/-1",
                     first_diff(pre0, e0), first_diff(pre1, e1));
        end
        rst = 1'b0;
        rec0 = {}; rec1 = {};
        repeat (60) step();
        rec_en = 1'b0;
        bad0 = 0; bad1 = 0;
        foreach (rec0[i]) if (rec0[i] !== 3'b001) bad0++;
        foreach (rec1[i]) if (rec1[i] !== 3'b001) bad1++;
        n_checks++;
        if (bad0 !== 0 || rec0.size() !== 60) begin
            n_fail++;
            $display("FAIL rst_mid_quiet8: got %0d non-idle samples of %0d, expected 0 of 60", bad0, rec0.size());
        end
        n_checks++;
        if (bad1 !== 0 || rec1.size() !== 60) begin
            n_fail++;
            $display("FAIL rst_mid_quiet7: got %0d non-idle samples of %0d, expected 0 of 60", bad1, rec1.size());
        end
        wait_idle();
    endtask

    task automatic test_seven_bit();
        int d, fi, di;
        baud_div = 16'd3; parity_en = 1'b0;
        clear_frames();
        queue_frame(8'h7F, 3, 1'b0, 1'b0);
        start_record();
        push_words();
        finish_record();
        d = first_diff(rec1, exp1); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL seven_wave7 sample %0d: got %b, expected %b", d, at(rec1, d), at(exp1, d));
        end
        d = first_diff(rec0, exp0); n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL seven_wave8 sample %0d: got %b, expected %b", d, at(rec0, d), at(exp0, d));
        end
        fi = -1; di = -1;
        for (int i = 0; i < rec1.size(); i++) begin
            if (fi < 0 && rec1[i][0] == 1'b0) fi = i;
            if (di < 0 && rec1[i][1] == 1'b1) di = i;
        end
        n_checks++;
        if (di - fi !== 30) begin
            n_fail++;
            $display("FAIL seven_frame_len: got %0d cycles fall-to-done, expected 30", di - fi);
        end
        wait_idle();
    endtask

    task automatic test_random();
        int d, n, b;
        bit pen, podd;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 9);
            b = $urandom_range(0, 5);
            pen = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            baud_div = DIV_W'(b); parity_en = pen; parity_odd = podd;
            clear_frames();
            for (int i = 0; i < n; i++) queue_frame(8'($urandom_range(0, 255)), b, pen, podd);
            start_record();
            push_words();
            finish_record();
            d = first_diff(rec0, exp0); n_checks++;
            if (d != -1) begin
                n_fail++;
                $display("FAIL random%0d_wave8 n=%0d div=%0d sample %0d: got %b, expected %b",
                         it, n, b, d, at(rec0, d), at(exp0, d));
            end
            d = first_diff(rec1, exp1); n_checks++;
            if (d != -1) begin
                n_fail++;
                $display("FAIL random%0d_wave7 n=%0d div=%0d sample %0d: got %b, expected %b",
                         it, n, b, d, at(rec1, d), at(exp1, d));
            end
            wait_idle();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_baud_change();
        test_reset_midframe();
        test_seven_bit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
